// File: rtl/adc_burst_adr_alloc.sv
// rtl/adc_burst_adr_alloc.sv - multi-channel DDR3 burst address allocator for ADC fills
//
// Each ADC channel owns a fixed DDR3 region of 2^REGION_LOG2 bursts starting at
// k << REGION_LOG2. A per-channel IDLE/FILLING state machine tracks the current
// fill, latches its start address, counts its bursts and emits a one-cycle
// completion record when the fill ends.
//
// Optional build macro: ADC_ADR_WRAP_PROTECT_EN
//   defined   - a channel whose offset has reached the top of its region drops
//               further bursts (pointer and length hold, wrap acts as "region full")
//   undefined - the offset wraps to 0 inside the region and wrap is set
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   init            synchronous clear of all channels (highest priority)
//   chan_sel        channel addressed by fill_start / fill_end
//   fill_start      begin (or restart) a fill on chan_sel
//   fill_end        end the fill on chan_sel
//   burst_wr        per-channel strobe, one burst written to DDR3
//   burst_adr       current burst address, channel k at [k*ADR_W +: ADR_W]
//   fill_active     channel is FILLING
//   wrap, err       sticky per-channel wrap / protocol-error flags
//   done_valid      one-cycle pulse, completion record valid
//   done_chan       channel of the completed fill
//   done_start_adr  first burst address of the completed fill
//   done_len        number of bursts in the completed fill (saturating)

module adc_burst_adr_alloc #(
    parameter int NCHAN       = 5,
    parameter int CHW         = 3,
    parameter int REGION_LOG2 = 20,
    parameter int ADR_W       = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init,
    input  logic [CHW-1:0]           chan_sel,
    input  logic                     fill_start,
    input  logic                     fill_end,
    input  logic [NCHAN-1:0]         burst_wr,
    output logic [NCHAN*ADR_W-1:0]   burst_adr,
    output logic [NCHAN-1:0]         fill_active,
    output logic [NCHAN-1:0]         wrap,
    output logic [NCHAN-1:0]         err,
    output logic                     done_valid,
    output logic [CHW-1:0]           done_chan,
    output logic [ADR_W-1:0]         done_start_adr,
    output logic [REGION_LOG2:0]     done_len
);

    localparam int LEN_W = REGION_LOG2 + 1;
    localparam logic [REGION_LOG2-1:0] OFF_MAX = '1;
    localparam logic [LEN_W-1:0]       LEN_MAX = LEN_W'(1) << REGION_LOG2;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_FILLING = 1'b1
    } chan_state_e;

    chan_state_e            state_q [NCHAN];
    chan_state_e            state_d [NCHAN];
    logic [REGION_LOG2-1:0] off_q   [NCHAN];
    logic [REGION_LOG2-1:0] off_d   [NCHAN];
    logic [LEN_W-1:0]       len_q   [NCHAN];
    logic [LEN_W-1:0]       len_d   [NCHAN];
    logic [ADR_W-1:0]       start_q [NCHAN];
    logic [ADR_W-1:0]       start_d [NCHAN];
    logic [ADR_W-1:0]       adr_cur [NCHAN];
    logic [LEN_W-1:0]       len_base[NCHAN];

    logic [NCHAN-1:0] wrap_q, wrap_d;
    logic [NCHAN-1:0] err_q, err_d;
    logic             done_valid_q, done_valid_d;
    logic [CHW-1:0]   done_chan_q, done_chan_d;
    logic [ADR_W-1:0] done_start_adr_q, done_start_adr_d;
    logic [LEN_W-1:0] done_len_q, done_len_d;

    // Per-channel decoded events
    logic [NCHAN-1:0] hit;        // chan_sel addresses this channel
    logic [NCHAN-1:0] start_ev;   // fill_start on this channel
    logic [NCHAN-1:0] end_ev;     // fill_end on this channel, not masked by fill_start
    logic [NCHAN-1:0] filling;    // currently in FILLING
    logic [NCHAN-1:0] active;     // a burst this cycle belongs to a fill
    logic [NCHAN-1:0] at_max;     // offset at top of region
    logic [NCHAN-1:0] take;       // burst accepted: pointer advances

    for (genvar k = 0; k < NCHAN; k++) begin : g_adr
        assign adr_cur[k] = (ADR_W'(k) << REGION_LOG2)
                          | {{(ADR_W-REGION_LOG2){1'b0}}, off_q[k]};
        assign burst_adr[k*ADR_W +: ADR_W] = adr_cur[k];
        assign fill_active[k] = (state_q[k] == ST_FILLING);
    end

    always_comb begin
        for (int i = 0; i < NCHAN; i++) begin
            hit[i]      = (chan_sel == CHW'(i));
            start_ev[i] = fill_start & hit[i];
            end_ev[i]   = fill_end & hit[i] & ~fill_start;
            filling[i]  = (state_q[i] == ST_FILLING);
            // A burst in the same cycle as fill_start counts toward the new fill.
            active[i]   = filling[i] | start_ev[i];
            at_max[i]   = (off_q[i] == OFF_MAX);
`ifdef ADC_ADR_WRAP_PROTECT_EN
            take[i]     = burst_wr[i] & active[i] & ~at_max[i];
`else
            take[i]     = burst_wr[i] & active[i];
`endif
            len_base[i] = start_ev[i] ? '0 : len_q[i];
        end
    end

    always_comb begin
        wrap_d           = wrap_q;
        err_d            = err_q;
        done_valid_d     = 1'b0;
        done_chan_d      = done_chan_q;
        done_start_adr_d = done_start_adr_q;
        done_len_d       = done_len_q;

        for (int i = 0; i < NCHAN; i++) begin
            state_d[i] = state_q[i];
            off_d[i]   = off_q[i];
            len_d[i]   = len_base[i];
            start_d[i] = start_q[i];

            if (take[i]) begin
                off_d[i] = off_q[i] + 1'b1;
                if (len_base[i] != LEN_MAX) begin
                    len_d[i] = len_base[i] + 1'b1;
                end
            end

`ifdef ADC_ADR_WRAP_PROTECT_EN
            // Region full: a burst arriving at the top offset is dropped.
            if (burst_wr[i] && active[i] && at_max[i]) begin
                wrap_d[i] = 1'b1;
            end
`else
            if (take[i] && at_max[i]) begin
                wrap_d[i] = 1'b1;
            end
`endif

            // Protocol errors: stray burst, restart, stray end, start+end clash.
            if ((burst_wr[i] && !active[i]) ||
                (start_ev[i] && filling[i]) ||
                (end_ev[i] && !filling[i]) ||
                (start_ev[i] && fill_end)) begin
                err_d[i] = 1'b1;
            end

            if (start_ev[i]) begin
                state_d[i] = ST_FILLING;
                start_d[i] = adr_cur[i];
            end else if (end_ev[i] && filling[i]) begin
                state_d[i]       = ST_IDLE;
                done_valid_d     = 1'b1;
                done_chan_d      = CHW'(i);
                done_start_adr_d = start_q[i];
                done_len_d       = len_d[i];
            end
        end

        if (init) begin
            for (int i = 0; i < NCHAN; i++) begin
                state_d[i] = ST_IDLE;
                off_d[i]   = '0;
                len_d[i]   = '0;
                start_d[i] = '0;
            end
            wrap_d           = '0;
            err_d            = '0;
            done_valid_d     = 1'b0;
            done_chan_d      = '0;
            done_start_adr_d = '0;
            done_len_d       = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCHAN; i++) begin
                state_q[i] <= ST_IDLE;
            end
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                state_q[i] <= state_d[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCHAN; i++) begin
                off_q[i]   <= '0;
                len_q[i]   <= '0;
                start_q[i] <= '0;
            end
            wrap_q           <= '0;
            err_q            <= '0;
            done_valid_q     <= 1'b0;
            done_chan_q      <= '0;
            done_start_adr_q <= '0;
            done_len_q       <= '0;
        end else begin
            for (int i = 0; i < NCHAN; i++) begin
                off_q[i]   <= off_d[i];
                len_q[i]   <= len_d[i];
                start_q[i] <= start_d[i];
            end
            wrap_q           <= wrap_d;
            err_q            <= err_d;
            done_valid_q     <= done_valid_d;
            done_chan_q      <= done_chan_d;
            done_start_adr_q <= done_start_adr_d;
            done_len_q       <= done_len_d;
        end
    end

    assign wrap           = wrap_q;
    assign err            = err_q;
    assign done_valid     = done_valid_q;
    assign done_chan      = done_chan_q;
    assign done_start_adr = done_start_adr_q;
    assign done_len       = done_len_q;

endmodule

// File: tb/tb_adc_burst_adr_alloc.sv
// tb/tb_adc_burst_adr_alloc.sv - directed self-checking bench for adc_burst_adr_alloc
module tb_adc_burst_adr_alloc;

    localparam int NCHAN = 5;
    localparam int CHW   = 3;
    localparam int ADR_W = 23;
    localparam int RL    = 20;
    localparam int RLW   = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   init = 1'b0;
    logic [CHW-1:0]         chan_sel = '0;
    logic                   fill_start = 1'b0;
    logic                   fill_end = 1'b0;
    logic [NCHAN-1:0]       burst_wr = '0;

    logic [NCHAN*ADR_W-1:0] burst_adr, burst_adr_w;
    logic [NCHAN-1:0]       fill_active, fill_active_w;
    logic [NCHAN-1:0]       wrap, wrap_w;
    logic [NCHAN-1:0]       err, err_w;
    logic                   done_valid, done_valid_w;
    logic [CHW-1:0]         done_chan, done_chan_w;
    logic [ADR_W-1:0]       done_start_adr, done_start_adr_w;
    logic [RL:0]            done_len;
    logic [RLW:0]           done_len_w;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    adc_burst_adr_alloc #(.NCHAN(NCHAN), .CHW(CHW), .REGION_LOG2(RL), .ADR_W(ADR_W)) dut (
        .clk(clk), .rst(rst), .init(init), .chan_sel(chan_sel),
        .fill_start(fill_start), .fill_end(fill_end), .burst_wr(burst_wr),
        .burst_adr(burst_adr), .fill_active(fill_active), .wrap(wrap), .err(err),
        .done_valid(done_valid), .done_chan(done_chan),
        .done_start_adr(done_start_adr), .done_len(done_len)
    );

    adc_burst_adr_alloc #(.NCHAN(NCHAN), .CHW(CHW), .REGION_LOG2(RLW), .ADR_W(ADR_W)) dut_w (
        .clk(clk), .rst(rst), .init(init), .chan_sel(chan_sel),
        .fill_start(fill_start), .fill_end(fill_end), .burst_wr(burst_wr),
        .burst_adr(burst_adr_w), .fill_active(fill_active_w), .wrap(wrap_w), .err(err_w),
        .done_valid(done_valid_w), .done_chan(done_chan_w),
        .done_start_adr(done_start_adr_w), .done_len(done_len_w)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        init       = 1'b0;
        fill_start = 1'b0;
        fill_end   = 1'b0;
        burst_wr   = '0;
    endtask

    function automatic logic [ADR_W-1:0] adr_of(input int k);
        return burst_adr[k*ADR_W +: ADR_W];
    endfunction

    function automatic logic [ADR_W-1:0] adr_w_of(input int k);
        return burst_adr_w[k*ADR_W +: ADR_W];
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset mid-fill
        chan_sel = 3'd2; fill_start = 1'b1; tick();
        burst_wr = 5'b00100; tick();
        burst_wr = 5'b00100; tick();
        check("pre_rst_adr2", adr_of(2), 23'h200002);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < NCHAN; k++) begin
            check($sformatf("rst_adr%0d", k), adr_of(k), 64'(k) << 20);
        end
        check("rst_active", fill_active, 5'b0);
        check("rst_wrap", wrap, 5'b0);
        check("rst_err", err, 5'b0);
        check("rst_done_valid", done_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Basic fill on ch2
        chan_sel = 3'd2; fill_start = 1'b1; tick();
        check("basic_active", fill_active, 5'b00100);
        repeat (3) begin
            burst_wr = 5'b00100; tick();
        end
        chan_sel = 3'd2; fill_end = 1'b1; tick();
        check("basic_done_valid", done_valid, 1'b1);
        check("basic_done_chan", done_chan, 3'd2);
        check("basic_done_start", done_start_adr, 23'h200000);
        check("basic_done_len", done_len, 21'd3);
        check("basic_adr2", adr_of(2), 23'h200003);
        check("basic_idle", fill_active, 5'b0);
        tick();
        check("basic_pulse_end", done_valid, 1'b0);

        // Same-cycle start+burst then end+burst on ch0
        chan_sel = 3'd0; fill_start = 1'b1; burst_wr = 5'b00001; tick();
        chan_sel = 3'd0; fill_end = 1'b1; burst_wr = 5'b00001; tick();
        check("same_done_valid", done_valid, 1'b1);
        check("same_done_chan", done_chan, 3'd0);
        check("same_done_start", done_start_adr, 23'h000000);
        check("same_done_len", done_len, 21'd2);
        check("same_adr0", adr_of(0), 23'h000002);
        check("same_err", err, 5'b0);

        // Protocol errors
        burst_wr = 5'b01000; tick();
        check("perr_err3", err, 5'b01000);
        check("perr_adr3", adr_of(3), 23'h300000);
        chan_sel = 3'd4; fill_end = 1'b1; tick();
        check("perr_err4", err, 5'b11000);
        check("perr_no_done", done_valid, 1'b0);
        chan_sel = 3'd7; fill_start = 1'b1; fill_end = 1'b1; tick();
        check("perr_badsel_err", err, 5'b11000);
        check("perr_badsel_act", fill_active, 5'b0);
        chan_sel = 3'd2; fill_start = 1'b1; fill_end = 1'b1; tick();
        check("perr_clash_err", err, 5'b11100);
        check("perr_clash_act", fill_active, 5'b00100);

        // Wrap on ch1 (small-region instance)
        init = 1'b1; tick();
        check("init_err", err, 5'b0);
        chan_sel = 3'd1; fill_start = 1'b1; tick();
        repeat (17) begin
            burst_wr = 5'b00010; tick();
        end
`ifdef ADC_ADR_WRAP_PROTECT_EN
        check("wrap_adr1_w", adr_w_of(1), 23'h00001F);
`else
        check("wrap_adr1_w", adr_w_of(1), 23'h000011);
`endif
        check("wrap_flag_w", wrap_w, 5'b00010);
        check("wrap_adr1_big", adr_of(1), 23'h100011);
        check("wrap_flag_big", wrap, 5'b0);
        chan_sel = 3'd1; fill_end = 1'b1; tick();
        check("wrap_done_valid_w", done_valid_w, 1'b1);
        check("wrap_done_start_w", done_start_adr_w, 23'h000010);
`ifdef ADC_ADR_WRAP_PROTECT_EN
        check("wrap_done_len_w", done_len_w, 5'd15);
`else
        check("wrap_done_len_w", done_len_w, 5'd16);
`endif
        check("wrap_done_len_big", done_len, 21'd17);
        tick();
        check("wrap_sticky_w", wrap_w, 5'b00010);

        // init priority
        chan_sel = 3'd3; fill_start = 1'b1; burst_wr = 5'b01000; tick();
        init = 1'b1; chan_sel = 3'd1; fill_start = 1'b1; burst_wr = 5'b11111; tick();
        for (int k = 0; k < NCHAN; k++) begin
            check($sformatf("init_adr%0d", k), adr_of(k), 64'(k) << 20);
        end
        check("init_active", fill_active, 5'b0);
        check("init_wrap_w", wrap_w, 5'b0);
        check("init_err2", err, 5'b0);
        check("init_done_valid", done_valid, 1'b0);
        check("init_done_len", done_len, 21'd0);

        // Independent multi-channel bursts
        chan_sel = 3'd0; fill_start = 1'b1; tick();
        chan_sel = 3'd4; fill_start = 1'b1; tick();
        burst_wr = 5'b10001; tick();
        burst_wr = 5'b10001; tick();
        check("multi_adr0", adr_of(0), 23'h000002);
        check("multi_adr4", adr_of(4), 23'h400002);
        check("multi_err", err, 5'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
